// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bundle of the register file's read, write, scoreboard and
// scrub signals.
//   master : drives read addresses, both write ports, scoreboard controls and
//            scrub_req; observes read data/busy, scrub_busy, any_busy.
//   slave  : the register file side of the same signals.
interface regfile_sb_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2
);
  localparam int unsigned AW = $clog2(NREG);

  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;

  logic                wa_en;
  logic [AW-1:0]       wa_addr;
  logic [XLEN-1:0]     wa_data;

  logic                wb_en;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;

  logic                sb_set;
  logic [AW-1:0]       sb_addr;
  logic                sb_flush;

  logic                scrub_req;
  logic                scrub_busy;
  logic                any_busy;

  modport master (
    output rs_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           sb_set, sb_addr, sb_flush, scrub_req,
    input  rs_data, rs_busy, scrub_busy, any_busy
  );

  modport slave (
    input  rs_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           sb_set, sb_addr, sb_flush, scrub_req,
    output rs_data, rs_busy, scrub_busy, any_busy
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read, dual-write integer register file with per-register
// pending-write scoreboard and a sequential scrub engine.
//   clk, rst : clock, synchronous active-high reset
//   bus      : regfile_sb_if slave modport
//              rs_addr/rs_data/rs_busy : NRD combinational read ports
//              wa_* : write port A (wins on same-address conflict)
//              wb_* : write port B, also clears the scoreboard bit
//              sb_set/sb_addr/sb_flush : scoreboard set and global clear
//              scrub_req/scrub_busy    : zero all registers, one per cycle
//              any_busy                : OR of stored scoreboard bits
module regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam int unsigned AW = $clog2(NREG);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SCRUB = 1'b1;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] busy_wr;
  logic [0:0]      state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;

  logic scrubbing;
  logic wa_ok, wb_ok, set_ok;

  // Port traffic is only accepted outside a scrub; x0 is never a target.
  assign scrubbing = (state_q == S_SCRUB);
  assign wa_ok  = bus.wa_en  && !scrubbing && (bus.wa_addr != '0);
  assign wb_ok  = bus.wb_en  && !scrubbing && (bus.wb_addr != '0);
  assign set_ok = bus.sb_set && !scrubbing && (bus.sb_addr != '0);

  // Scoreboard next state from port traffic only: flush, then clear, then set.
  always_comb begin
    busy_wr = bus.sb_flush ? '0 : busy_q;
    if (wb_ok)  busy_wr[bus.wb_addr] = 1'b0;
    if (set_ok) busy_wr[bus.sb_addr] = 1'b1;
  end

  // Register/scoreboard/FSM next state; scrub writes layered over port traffic.
  always_comb begin
    regs_d  = regs_q;
    busy_d  = busy_wr;
    state_d = state_q;
    idx_d   = idx_q;
    if (wb_ok) regs_d[bus.wb_addr] = bus.wb_data;
    if (wa_ok) regs_d[bus.wa_addr] = bus.wa_data;
    case (state_q)
      S_IDLE: begin
        if (bus.scrub_req) begin
          state_d = S_SCRUB;
          idx_d   = AW'(1);
        end
      end
      S_SCRUB: begin
        regs_d[idx_q] = '0;
        busy_d[idx_q] = 1'b0;
        idx_d         = idx_q + AW'(1);
        if (idx_q == AW'(NREG - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
      busy_q  <= '0;
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Read ports; reset and x0 force zero, bypass forwards accepted writes.
  for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] rd;
    logic            bsy;

    assign a = bus.rs_addr[k*AW +: AW];

    always_comb begin
      rd  = regs_q[a];
      bsy = busy_q[a];
      if (BYPASS != 0) begin
        if (wb_ok && (bus.wb_addr == a)) rd = bus.wb_data;
        if (wa_ok && (bus.wa_addr == a)) rd = bus.wa_data;
        bsy = busy_wr[a];
      end
      if (rst || (a == '0)) begin
        rd  = '0;
        bsy = 1'b0;
      end
    end

    assign bus.rs_data[k*XLEN +: XLEN] = rd;
    assign bus.rs_busy[k]              = bsy;
  end

  assign bus.scrub_busy = scrubbing;
  assign bus.any_busy   = |busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: the driver computes expected outputs from a behavioural
// model and queues them; a negedge monitor pops and compares. Two DUTs (with
// and without bypass) share identical stimulus.
module tb_regfile_sb;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned NRD  = 2;
  localparam int unsigned AW   = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus1 ();
  regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus0 ();

  assign bus0.rs_addr   = bus1.rs_addr;
  assign bus0.wa_en     = bus1.wa_en;
  assign bus0.wa_addr   = bus1.wa_addr;
  assign bus0.wa_data   = bus1.wa_data;
  assign bus0.wb_en     = bus1.wb_en;
  assign bus0.wb_addr   = bus1.wb_addr;
  assign bus0.wb_data   = bus1.wb_data;
  assign bus0.sb_set    = bus1.sb_set;
  assign bus0.sb_addr   = bus1.sb_addr;
  assign bus0.sb_flush  = bus1.sb_flush;
  assign bus0.scrub_req = bus1.scrub_req;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));
  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));

  typedef struct packed {
    logic [NRD*XLEN-1:0] d1;
    logic [NRD*XLEN-1:0] d0;
    logic [NRD-1:0]      b1;
    logic [NRD-1:0]      b0;
    logic                sb;
    logic                ab;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Behavioural model: architectural contents, pending bits, scrub progress.
  logic [XLEN-1:0] mreg [NREG];
  bit              mbusy [NREG];
  int              scrub_left = 0;
  int              scrub_idx  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
    end
  endtask

  // Monitor: every queued expectation is compared against both DUTs.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rs_data_byp",    64'(bus1.rs_data),    64'(e.d1));
      chk("rs_busy_byp",    64'(bus1.rs_busy),    64'(e.b1));
      chk("rs_data_nobyp",  64'(bus0.rs_data),    64'(e.d0));
      chk("rs_busy_nobyp",  64'(bus0.rs_busy),    64'(e.b0));
      chk("scrub_busy",     64'(bus1.scrub_busy), 64'(e.sb));
      chk("any_busy",       64'(bus1.any_busy),   64'(e.ab));
      chk("scrub_busy_nb",  64'(bus0.scrub_busy), 64'(e.sb));
      chk("any_busy_nb",    64'(bus0.any_busy),   64'(e.ab));
    end
  end

  task automatic set_idle();
    rst            = 1'b0;
    bus1.wa_en     = 1'b0;
    bus1.wa_addr   = '0;
    bus1.wa_data   = '0;
    bus1.wb_en     = 1'b0;
    bus1.wb_addr   = '0;
    bus1.wb_data   = '0;
    bus1.sb_set    = 1'b0;
    bus1.sb_addr   = '0;
    bus1.sb_flush  = 1'b0;
    bus1.scrub_req = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    bus1.rs_addr = {AW'(a1), AW'(a0)};
  endtask

  // Queue this cycle's expectation, advance the model, then cross the edge.
  task automatic tick();
    exp_t e;
    bit   scr;
    int   wa, wb, sa;
    scr = (scrub_left > 0);
    wa  = int'(bus1.wa_addr);
    wb  = int'(bus1.wb_addr);
    sa  = int'(bus1.sb_addr);
    e   = '0;
    for (int k = 0; k < int'(NRD); k++) begin
      int              a;
      logic [XLEN-1:0] d1, d0;
      logic            b1, b0;
      a = int'(bus1.rs_addr[k*AW +: AW]);
      if (rst || a == 0) begin
        d1 = '0; d0 = '0; b1 = 1'b0; b0 = 1'b0;
      end else begin
        d0 = mreg[a];
        b0 = mbusy[a];
        d1 = mreg[a];
        if (!scr && bus1.wa_en && wa == a)      d1 = bus1.wa_data;
        else if (!scr && bus1.wb_en && wb == a) d1 = bus1.wb_data;
        b1 = bus1.sb_flush ? 1'b0 : mbusy[a];
        if (!scr && bus1.wb_en && wb == a)  b1 = 1'b0;
        if (!scr && bus1.sb_set && sa == a) b1 = 1'b1;
      end
      e.d1[k*XLEN +: XLEN] = d1;
      e.d0[k*XLEN +: XLEN] = d0;
      e.b1[k] = b1;
      e.b0[k] = b0;
    end
    e.sb = scr;
    e.ab = 1'b0;
    for (int i = 0; i < int'(NREG); i++) e.ab = e.ab | mbusy[i];
    q.push_back(e);

    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        mreg[i] = '0; mbusy[i] = 1'b0;
      end
      scrub_left = 0;
    end else if (scr) begin
      if (bus1.sb_flush) for (int i = 0; i < int'(NREG); i++) mbusy[i] = 1'b0;
      mreg[scrub_idx]  = '0;
      mbusy[scrub_idx] = 1'b0;
      scrub_idx++;
      scrub_left--;
    end else begin
      if (bus1.wb_en && wb != 0) mreg[wb] = bus1.wb_data;
      if (bus1.wa_en && wa != 0) mreg[wa] = bus1.wa_data;
      if (bus1.sb_flush) for (int i = 0; i < int'(NREG); i++) mbusy[i] = 1'b0;
      if (bus1.wb_en)  mbusy[wb] = 1'b0;
      if (bus1.sb_set && sa != 0) mbusy[sa] = 1'b1;
      if (bus1.scrub_req) begin
        scrub_left = int'(NREG) - 1;
        scrub_idx  = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill_index();
    for (int i = 1; i < int'(NREG); i++) begin
      set_idle();
      bus1.wa_en   = 1'b1;
      bus1.wa_addr = AW'(i);
      bus1.wa_data = XLEN'(i);
      set_rd(i, i - 1);
      tick();
    end
    set_idle();
  endtask

  task automatic read_all();
    set_idle();
    for (int i = 0; i < int'(NREG); i += 2) begin
      set_rd(i, i + 1);
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    set_idle();
    set_rd(0, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Second reset cycle: outputs must already read zero despite a write.
    rst = 1'b1;
    bus1.wa_en = 1'b1; bus1.wa_addr = AW'(5); bus1.wa_data = 32'hDEADBEEF;
    tick();

    // x0 is hardwired to zero.
    set_idle();
    bus1.wa_en = 1'b1; bus1.wa_addr = '0; bus1.wa_data = 32'hDEADBEEF;
    set_rd(0, 1);
    tick();
    set_idle(); set_rd(0, 0); tick();

    // Dual-write conflict on x5: port A wins, same cycle and next.
    bus1.wa_en = 1'b1; bus1.wa_addr = AW'(5); bus1.wa_data = 32'h11;
    bus1.wb_en = 1'b1; bus1.wb_addr = AW'(5); bus1.wb_data = 32'h22;
    set_rd(5, 5);
    tick();
    set_idle(); set_rd(5, 0); tick();

    // Scoreboard set, then cleared by a port-B return.
    bus1.sb_set = 1'b1; bus1.sb_addr = AW'(7); set_rd(7, 5);
    tick();
    set_idle(); set_rd(7, 0); tick();
    bus1.wb_en = 1'b1; bus1.wb_addr = AW'(7); bus1.wb_data = 32'h55;
    tick();
    set_idle(); tick();

    // Set/clear collision, then flush with a concurrent set.
    bus1.sb_set = 1'b1; bus1.sb_addr = AW'(9);
    bus1.wb_en = 1'b1;  bus1.wb_addr = AW'(9); bus1.wb_data = 32'h99;
    set_rd(9, 7);
    tick();
    set_idle(); set_rd(9, 3); tick();
    bus1.sb_flush = 1'b1; bus1.sb_set = 1'b1; bus1.sb_addr = AW'(3);
    tick();
    set_idle(); set_rd(3, 9); tick();

    // Port writes with bypass vs stored view.
    bus1.wa_en = 1'b1; bus1.wa_addr = AW'(4); bus1.wa_data = 32'h44;
    set_rd(4, 4);
    tick();
    set_idle(); tick();

    // Full scrub with a dropped mid-scrub write.
    fill_index();
    bus1.scrub_req = 1'b1; set_rd(12, 31);
    tick();
    set_idle();
    n = 0;
    while (bus1.scrub_busy === 1'b1 && n < 100) begin
      n++;
      if (n == 5) begin
        bus1.wa_en = 1'b1; bus1.wa_addr = AW'(12); bus1.wa_data = 32'hFF;
        bus1.sb_set = 1'b1; bus1.sb_addr = AW'(20);
      end else begin
        set_idle();
      end
      set_rd(12, 20);
      tick();
    end
    chk("scrub_len", 64'(n), 64'(NREG - 1));
    read_all();

    // Reset in the middle of a scrub.
    fill_index();
    bus1.sb_set = 1'b1; bus1.sb_addr = AW'(25);
    bus1.scrub_req = 1'b1;
    tick();
    set_idle();
    for (int i = 0; i < 9; i++) begin
      set_rd(i, 30);
      tick();
    end
    rst = 1'b1;
    tick();
    read_all();

    // Randomized traffic.
    for (int it = 0; it < 1500; it++) begin
      int ra0, ra1;
      set_idle();
      rst            = ($urandom_range(0, 299) == 0);
      bus1.wa_en     = $urandom_range(0, 1) == 1;
      bus1.wa_addr   = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      bus1.wa_data   = $urandom;
      bus1.wb_en     = $urandom_range(0, 2) == 0;
      bus1.wb_addr   = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      bus1.wb_data   = $urandom;
      bus1.sb_set    = $urandom_range(0, 2) == 0;
      bus1.sb_addr   = AW'($urandom_range(0, 7));
      bus1.sb_flush  = $urandom_range(0, 19) == 0;
      bus1.scrub_req = $urandom_range(0, 59) == 0;
      case ($urandom_range(0, 3))
        0: ra0 = int'(bus1.wa_addr);
        1: ra0 = int'(bus1.wb_addr);
        2: ra0 = int'(bus1.sb_addr);
        default: ra0 = int'($urandom_range(0, 31));
      endcase
      ra1 = $urandom_range(0, 1) ? int'($urandom_range(0, 7)) : int'(bus1.wb_addr);
      set_rd(ra0, ra1);
      tick();
    end

    set_idle();
    read_all();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
